// File: rtl/binary_multiplier_if.sv
// Operand and result bundle for the iterative shift-and-add multiplier.
interface binary_multiplier_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   input1;
    logic [WIDTH-1:0]   input2;
    logic [2*WIDTH-1:0] result;
    logic               valid;

    modport master (
        output input1,
        output input2,
        input  result,
        input  valid
    );

    modport slave (
        input  input1,
        input  input2,
        output result,
        output valid
    );
endinterface

// File: rtl/binary_multiplier.sv
// Free-running shift-and-add unsigned multiplier: LOAD, WIDTH x CALC, DONE.
// The registered result updates once per WIDTH+2 cycles, with a one-cycle valid pulse.
module binary_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    binary_multiplier_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [RW-1:0]    m_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]    p_q;
    logic [CW-1:0]    count_q;
    logic [RW-1:0]    result_q;
    logic             valid_q;
    logic [RW-1:0]    p_d;

    // Partial product cannot overflow: (2^W-1)^2 < 2^(2W).
    assign p_d = b_q[0] ? (p_q + m_q) : p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            m_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            count_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    m_q     <= RW'(bus.input1);
                    b_q     <= bus.input2;
                    p_q     <= '0;
                    count_q <= '0;
                    valid_q <= 1'b0;
                    state_q <= CALC;
                end
                CALC: begin
                    p_q     <= p_d;
                    m_q     <= m_q << 1;
                    b_q     <= b_q >> 1;
                    count_q <= count_q + 1'b1;
                    valid_q <= 1'b0;
                    if (count_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    result_q <= p_q;
                    valid_q  <= 1'b1;
                    state_q  <= LOAD;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.valid  = valid_q;
endmodule

// File: tb/tb_binary_multiplier.sv
// Scoreboard bench for binary_multiplier: directed cases from the test plan plus random operands.
module tb_binary_multiplier;
    localparam int W = 4;
    localparam int P = W + 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    binary_multiplier_if #(.WIDTH(W)) bus ();

    binary_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference timing: first edge after release is a capture edge, then every P edges.
    int             ph;
    bit             exp_vld;
    logic [2*W-1:0] sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      = 0;
            exp_vld = 1'b0;
            sb.delete();
        end else begin
            if (ph == 0) sb.push_back(prod(bus.input1, bus.input2));
            exp_vld = (ph == W + 1);
            ph      = (ph + 1) % P;
        end
    end

    logic [2*W-1:0] last_res;
    logic [2*W-1:0] exp_res;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_result", 32'(bus.result), 32'd0);
            check("reset_valid", 32'(bus.valid), 32'd0);
            last_res = '0;
        end else begin
            check("valid_timing", 32'(bus.valid), 32'(exp_vld));
            if (bus.valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty: got result %0d with no expected entry", bus.result);
                end else begin
                    exp_res  = sb.pop_front();
                    check("product", 32'(bus.result), 32'(exp_res));
                    last_res = exp_res;
                end
            end else begin
                check("result_hold", 32'(bus.result), 32'(last_res));
            end
        end
    end

    task automatic wait_valid(input string name, input logic [2*W-1:0] exp, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.valid !== 1'b1 && n < 2 * P);
        if (bus.valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: valid not seen within %0d cycles, required result %0d", name, 2 * P, exp);
        end else begin
            check(name, 32'(bus.result), 32'(exp));
        end
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t bnd[4];
    int   n;

    initial begin
        total = 0;
        bad   = 0;
        bnd[0] = '{a: 4'd15, b: 4'd15, p: 8'd225};
        bnd[1] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
        bnd[2] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
        bnd[3] = '{a: 4'd15, b: 4'd1,  p: 8'd15};

        rst_n      = 1'b0;
        bus.input1 = 4'd13;
        bus.input2 = 4'd5;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;

        wait_valid("basic_13x5", 8'd65, n);
        check("first_latency", 32'(n), 32'(P));
        wait_valid("basic_13x5_repeat", 8'd65, n);
        check("basic_period", 32'(n), 32'(P));

        foreach (bnd[i]) begin
            bus.input1 = bnd[i].a;
            bus.input2 = bnd[i].b;
            wait_valid($sformatf("boundary_%0dx%0d", bnd[i].a, bnd[i].b), bnd[i].p, n);
        end

        // Change operands one CALC edge after capture; the in-flight product must not notice.
        bus.input1 = 4'd13;
        bus.input2 = 4'd5;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.input1 = 4'd3;
        bus.input2 = 4'd3;
        wait_valid("midchange_first", 8'd65, n);
        wait_valid("midchange_second", 8'd9, n);

        bus.input1 = 4'd13;
        bus.input2 = 4'd5;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_result", 32'(bus.result), 32'd0);
        check("async_reset_valid", 32'(bus.valid), 32'd0);
        bus.input1 = 4'd6;
        bus.input2 = 4'd7;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_valid("post_reset_6x7", 8'd42, n);
        check("post_reset_latency", 32'(n), 32'(P));

        for (int i = 0; i < 200; i++) begin
            bus.input1 = W'($urandom_range(0, (1 << W) - 1));
            bus.input2 = W'($urandom_range(0, (1 << W) - 1));
            repeat ($urandom_range(P, P + 3)) @(negedge clk);
        end
        repeat (2 * P) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/binary_multiplier.md
Name: binary_multiplier

Overview:
- Iterative shift-and-add unsigned multiplier, free-running.
- Repeatedly samples two WIDTH-bit operands, computes their product over WIDTH clock cycles, and publishes it on a registered result bus.
- No start/enable handshake. Downstream logic reads `result`, which always holds the most recently completed product, and may use the `valid` strobe.

Parameters:
- WIDTH, default 4: operand width in bits. The result is 2*WIDTH bits. Legal values are 2..16.

Ports:
- clk, input, 1: single clock, rising-edge active.
- rst_n, input, 1: asynchronous, active-low reset.
- input1, input, WIDTH: multiplicand, unsigned.
- input2, input, WIDTH: multiplier, unsigned.
- result, output, 2*WIDTH: last completed product, registered.
- valid, output, 1: one-cycle pulse, high in the cycle after `result` is updated.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - state=LOAD
  - result=0, valid=0
  - internal registers (M, B, P, count) cleared
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Deassertion is sampled on the next rising clk edge.
- FSM states: LOAD, CALC, DONE. All transitions occur on rising clk.
- LOAD (one edge):
  - M <= zero-extended input1 (2*WIDTH bits)
  - B <= input2
  - P <= 0
  - count <= 0
  - next state CALC
  - valid <= 0
- CALC (exactly WIDTH edges):
  - If B[0]=1, P <= P + M; otherwise P holds.
  - M <= M << 1
  - B <= B >> 1
  - count <= count + 1
  - When count = WIDTH-1 on this edge, next state is DONE; otherwise stay in CALC.
- DONE (one edge):
  - result <= P
  - valid <= 1
  - next state LOAD
- valid is high for exactly the single cycle following the DONE edge, and 0 at all other times.
- Iteration period is WIDTH+2 clock cycles (6 for WIDTH=4).
- Latency: operands sampled at the LOAD edge appear on `result` at the DONE edge, WIDTH+1 edges later (5 for WIDTH=4).
- Operand changes during CALC or DONE are ignored until the next LOAD edge. The in-flight computation always uses the values captured at LOAD.
- result holds its value between DONE edges. Glitch-free, since it is driven only by a register.
- Arithmetic:
  - unsigned
  - P is 2*WIDTH bits and cannot overflow, since max (2^W-1)^2 < 2^(2W)
  - no truncation
- Reset mid-operation aborts the computation: result=0, valid=0, and operation restarts at LOAD after release.
- First valid product after reset release: the first LOAD edge captures the operands; result updates WIDTH+1 edges later.
- Zero operand on either input yields result=0 and valid still pulses.

Test Plan:
- Reset: hold rst_n=0 across several edges with inputs 13/5 -> result=0x00, valid=0 throughout. Assert rst_n asynchronously between edges -> outputs clear immediately.
- Basic product: release reset, input1=4'b1101 (13), input2=4'b0101 (5) held -> after at most 2*(WIDTH+2) cycles result=8'b01000001 (65), valid pulses once every 6 cycles, and result stays 65.
- Boundaries, each held for a full period:
  - 15×15 -> 225 (0xE1)
  - 0×9 -> 0
  - 1×1 -> 1
  - 15×1 -> 15
- Mid-computation input change: 13×5 captured at LOAD, then change to 3×3 during CALC -> next DONE gives 65, and the following DONE gives 9.
- Reset mid-operation: assert rst_n=0 during CALC of 13×5 -> result=0, valid=0. After release with 6×7 -> result=42 at the first DONE edge, 5 edges after the first LOAD edge.
- Randomized: 200 random operand pairs, each held ≥6 cycles -> result equals input1*input2 at each valid pulse, compared against a reference model.
